// File: rtl/reg_bus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_pkg
//   Shared definitions for the register-file bus: master FSM state encoding,
//   default bus geometry and the word size in bytes. Imported by the bus
//   master, the register block and the bench.
// -----------------------------------------------------------------------------
package reg_bus_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_e;

   localparam int AW_DEFAULT         = 10;
   localparam int DW_DEFAULT         = 32;
   localparam int MAX_BURST_DEFAULT  = 16;
   localparam int RD_LATENCY_DEFAULT = 1;
   localparam int WORD_BYTES         = 4;

   // A byte address is usable on the bus only if it names a whole 32-bit word.
   function automatic logic word_misaligned(input logic [1:0] lsb_s);
      return (lsb_s != 2'b00);
   endfunction

endpackage

// File: rtl/reg_bus_master.sv
// -----------------------------------------------------------------------------
// reg_bus_master
//   Sole initiator on the register-file bus. Commands arrive on a valid/ready
//   port (single writes, incrementing read bursts of 1..MAX_BURST words) and
//   are turned into one bus access at a time; every write and every read word
//   produces one response beat on a second valid/ready port. Malformed
//   commands (misaligned address, read length 0 or above MAX_BURST) are
//   answered with an error beat and never reach the bus.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/addr/wdata/len        command fields (len only for reads)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err/rsp_last      response payload
//   wr_en/rd_en/addr/wdata          registered bus strobes, address, data
//   rdata                           bus read data, RD_LATENCY after rd_en
// -----------------------------------------------------------------------------
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int AW          = AW_DEFAULT,
   parameter int DW          = DW_DEFAULT,
   parameter int MAX_BURST   = MAX_BURST_DEFAULT,
   parameter int RD_LATENCY  = RD_LATENCY_DEFAULT,
   localparam int LW         = $clog2(MAX_BURST + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [LW-1:0] cmd_len,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          rsp_last,
   output logic          wr_en,
   output logic          rd_en,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   input  logic [DW-1:0] rdata
);

   // Wait counter counts down from RD_LATENCY-1 to 0, one step per WAIT cycle.
   localparam int LATW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [LW-1:0]   ONE_BEAT   = LW'(1);
   localparam logic [LW-1:0]   MAX_LEN    = LW'(MAX_BURST);
   localparam logic [LATW-1:0] LAT_START  = LATW'(RD_LATENCY - 1);
   localparam logic [AW-1:0]   ADDR_STEP  = AW'(WORD_BYTES);

   state_e          state_r,     state_s;
   logic            cmd_ready_r, cmd_ready_s;
   logic            rsp_valid_r, rsp_valid_s;
   logic [DW-1:0]   rsp_rdata_r, rsp_rdata_s;
   logic            rsp_err_r,   rsp_err_s;
   logic            rsp_last_r,  rsp_last_s;
   logic            wr_en_r,     wr_en_s;
   logic            rd_en_r,     rd_en_s;
   logic [AW-1:0]   addr_r,      addr_s;
   logic [DW-1:0]   wdata_r,     wdata_s;
   logic [LW-1:0]   beats_r,     beats_s;   // read words still owed, incl. current
   logic [LATW-1:0] lat_r,       lat_s;

   // Rejection rule: misaligned address for any command, bad length for reads.
   function automatic logic cmd_reject(input logic          wr_s,
                                       input logic [1:0]    lsb_s,
                                       input logic [LW-1:0] len_s);
      logic bad_len_s;
      bad_len_s = (len_s == {LW{1'b0}}) || (len_s > MAX_LEN);
      return word_misaligned(lsb_s) || (!wr_s && bad_len_s);
   endfunction

   // Next-state and next-output logic; every output is computed here and
   // registered below, so bus and response ports come straight from flops.
   always_comb begin
      state_s     = state_r;
      cmd_ready_s = 1'b0;
      rsp_valid_s = rsp_valid_r;
      rsp_rdata_s = rsp_rdata_r;
      rsp_err_s   = rsp_err_r;
      rsp_last_s  = rsp_last_r;
      wr_en_s     = 1'b0;
      rd_en_s     = 1'b0;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      beats_s     = beats_r;
      lat_s       = lat_r;

      case (state_r)
         IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               if (cmd_reject(cmd_write, cmd_addr[1:0], cmd_len)) begin
                  // Error beat goes out directly; bus address/data untouched.
                  state_s     = RESP;
                  rsp_valid_s = 1'b1;
                  rsp_rdata_s = {DW{1'b0}};
                  rsp_err_s   = 1'b1;
                  rsp_last_s  = 1'b1;
                  beats_s     = {LW{1'b0}};
               end else if (cmd_write) begin
                  state_s = WRITE;
                  wr_en_s = 1'b1;
                  addr_s  = cmd_addr;
                  wdata_s = cmd_wdata;
                  beats_s = {LW{1'b0}};
               end else begin
                  state_s = READ;
                  rd_en_s = 1'b1;
                  addr_s  = cmd_addr;
                  beats_s = cmd_len;
               end
            end else begin
               cmd_ready_s = 1'b1;
            end
         end

         WRITE: begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_rdata_s = {DW{1'b0}};
            rsp_err_s   = 1'b0;
            rsp_last_s  = 1'b1;
         end

         READ: begin
            state_s = WAIT;
            lat_s   = LAT_START;
         end

         WAIT: begin
            if (lat_r == {LATW{1'b0}}) begin
               // rdata is valid in this cycle; capture it as the response.
               state_s     = RESP;
               rsp_valid_s = 1'b1;
               rsp_rdata_s = rdata;
               rsp_err_s   = 1'b0;
               rsp_last_s  = (beats_r == ONE_BEAT);
            end else begin
               lat_s = lat_r - LATW'(1);
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               rsp_rdata_s = {DW{1'b0}};
               rsp_err_s   = 1'b0;
               rsp_last_s  = 1'b0;
               if (beats_r > ONE_BEAT) begin
                  // Address wraps naturally at the top of the AW-bit space.
                  state_s = READ;
                  rd_en_s = 1'b1;
                  addr_s  = addr_r + ADDR_STEP;
                  beats_s = beats_r - ONE_BEAT;
               end else begin
                  state_s     = IDLE;
                  cmd_ready_s = 1'b1;
                  beats_s     = {LW{1'b0}};
               end
            end else begin
               state_s = RESP;
            end
         end

         default: begin
            // Unreachable encodings recover to a quiet idle.
            state_s     = IDLE;
            rsp_valid_s = 1'b0;
            rsp_rdata_s = {DW{1'b0}};
            rsp_err_s   = 1'b0;
            rsp_last_s  = 1'b0;
            beats_s     = {LW{1'b0}};
            lat_s       = {LATW{1'b0}};
         end
      endcase
   end

   // State and output registers; reset clears everything, aborting any command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cmd_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DW{1'b0}};
         rsp_err_r   <= 1'b0;
         rsp_last_r  <= 1'b0;
         wr_en_r     <= 1'b0;
         rd_en_r     <= 1'b0;
         addr_r      <= {AW{1'b0}};
         wdata_r     <= {DW{1'b0}};
         beats_r     <= {LW{1'b0}};
         lat_r       <= {LATW{1'b0}};
      end else begin
         state_r     <= state_s;
         cmd_ready_r <= cmd_ready_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         rsp_err_r   <= rsp_err_s;
         rsp_last_r  <= rsp_last_s;
         wr_en_r     <= wr_en_s;
         rd_en_r     <= rd_en_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         beats_r     <= beats_s;
         lat_r       <= lat_s;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_last  = rsp_last_r;
   assign wr_en     = wr_en_r;
   assign rd_en     = rd_en_r;
   assign addr      = addr_r;
   assign wdata     = wdata_r;

endmodule

// File: tb/tb_reg_bus_master.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_master
//   Drives reg_bus_master against a simple register block (registered read,
//   cleared by reset). A command-level model predicts bus accesses and
//   response beats; a negedge monitor compares the DUT against it, and the
//   directed sequence pins key results with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_reg_bus_master;
   import reg_bus_pkg::*;

   localparam int AW         = 10;
   localparam int DW         = 32;
   localparam int MAX_BURST  = 16;
   localparam int RD_LATENCY = 1;
   localparam int LW         = $clog2(MAX_BURST + 1);
   localparam int NWORDS     = 1 << (AW - 2);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [LW-1:0] cmd_len;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_last;
   logic [DW-1:0] rsp_rdata;
   logic          wr_en, rd_en;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, rdata;

   always #5 clk = ~clk;

   reg_bus_master #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .RD_LATENCY(RD_LATENCY)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_last(rsp_last),
      .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata)
   );

   // Register block: one-cycle registered read, contents cleared by reset.
   logic [DW-1:0] regs [0:NWORDS-1];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NWORDS; i++) regs[i] <= '0;
         rdata <= '0;
      end else begin
         if (wr_en) regs[addr[AW-1:2]] <= wdata;
         if (rd_en) rdata <= regs[addr[AW-1:2]];
      end
   end

   // ---------------- model and scoreboard ----------------
   typedef struct packed { logic [DW-1:0] rdata; logic err; logic last; } rsp_t;
   typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } bus_t;

   logic [DW-1:0] mem_m [0:NWORDS-1];
   rsp_t          rsp_q[$];
   bus_t          bus_q[$];
   logic [DW-1:0] cap_rdata[$];
   logic          cap_err[$];
   logic          cap_last[$];
   logic [AW-1:0] bus_log[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Predict bus accesses and response beats of one command from its meaning.
   task automatic model_cmd(input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int len);
      bus_t b;
      rsp_t r;
      int   ba;
      if (a[1:0] != 2'b00 || (!wr && (len < 1 || len > MAX_BURST))) begin
         r.rdata = '0; r.err = 1'b1; r.last = 1'b1;
         rsp_q.push_back(r);
      end else if (wr) begin
         mem_m[a[AW-1:2]] = d;
         b.wr = 1'b1; b.addr = a; b.wdata = d;
         bus_q.push_back(b);
         r.rdata = '0; r.err = 1'b0; r.last = 1'b1;
         rsp_q.push_back(r);
      end else begin
         for (int i = 0; i < len; i++) begin
            ba = (int'(a) + i * WORD_BYTES) % (1 << AW);
            b.wr = 1'b0; b.addr = AW'(ba); b.wdata = '0;
            bus_q.push_back(b);
            r.rdata = mem_m[ba / WORD_BYTES]; r.err = 1'b0; r.last = (i == len - 1);
            rsp_q.push_back(r);
         end
      end
   endtask

   // Monitor: compares every bus access and response handshake to the model.
   bus_t            mb;
   rsp_t            mr;
   logic            hold_p = 1'b0;
   logic [DW+1:0]   prev_payload;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("strobe_exclusive", {63'd0, wr_en & rd_en}, 64'd0);
         if (wr_en || rd_en) begin
            bus_log.push_back(addr);
            if (bus_q.size() == 0) begin
               chk("unexpected_strobe", {63'd0, wr_en | rd_en}, 64'd0);
            end else begin
               mb = bus_q.pop_front();
               chk("bus_dir", {63'd0, wr_en}, {63'd0, mb.wr});
               chk("bus_addr", 64'(addr), 64'(mb.addr));
               if (mb.wr) chk("bus_wdata", 64'(wdata), 64'(mb.wdata));
            end
         end
         if (hold_p) begin
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_payload", 64'({rsp_rdata, rsp_err, rsp_last}), 64'(prev_payload));
         end
         if (rsp_valid && rsp_ready) begin
            cap_rdata.push_back(rsp_rdata);
            cap_err.push_back(rsp_err);
            cap_last.push_back(rsp_last);
            if (rsp_q.size() == 0) begin
               chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
               mr = rsp_q.pop_front();
               chk("rsp_rdata", 64'(rsp_rdata), 64'(mr.rdata));
               chk("rsp_err", {63'd0, rsp_err}, {63'd0, mr.err});
               chk("rsp_last", {63'd0, rsp_last}, {63'd0, mr.last});
            end
         end
         hold_p       = rsp_valid && !rsp_ready;
         prev_payload = {rsp_rdata, rsp_err, rsp_last};
      end else begin
         hold_p = 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Present a command and return one cycle after acceptance (#1 past the edge).
   task automatic send(input logic wr, input int a, input logic [DW-1:0] d, input int len);
      logic got;
      got = 1'b0;
      model_cmd(wr, AW'(a), d, len);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AW'(a);
      cmd_wdata = d;    cmd_len   = LW'(len);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (cmd_ready) begin got = 1'b1; break; end
      end
      chk("cmd_accept", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rsp_q.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
      end
      chk("drain_rsp", {63'd0, ok}, 64'd1);
      chk("drain_bus", 64'(bus_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      cap_rdata.delete(); cap_err.delete(); cap_last.delete(); bus_log.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
      chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
      chk({tag, "_rsp_err"},   {63'd0, rsp_err}, 64'd0);
      chk({tag, "_rsp_last"},  {63'd0, rsp_last}, 64'd0);
      chk({tag, "_wr_en"},     {63'd0, wr_en}, 64'd0);
      chk({tag, "_rd_en"},     {63'd0, rd_en}, 64'd0);
      chk({tag, "_addr"},      64'(addr), 64'd0);
      chk({tag, "_wdata"},     64'(wdata), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b1;
      for (int i = 0; i < NWORDS; i++) mem_m[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

      // Write then single read of word 0, with latency pinned.
      clear_logs();
      send(1'b1, 'h000, 32'hF0F0F0F0, 0);
      chk("wr_lat_wr_en", {63'd0, wr_en}, 64'd1);
      chk("wr_lat_early", {63'd0, rsp_valid}, 64'd0);
      @(posedge clk); #1;
      chk("wr_lat_rsp", {63'd0, rsp_valid}, 64'd1);
      wait_done();
      chk("wr_ack_err", {63'd0, cap_err[0]}, 64'd0);
      chk("wr_ack_last", {63'd0, cap_last[0]}, 64'd1);
      clear_logs();
      send(1'b0, 'h000, 32'h0, 1);
      chk("rd_lat_rd_en", {63'd0, rd_en}, 64'd1);
      @(posedge clk); #1;
      chk("rd_lat_early", {63'd0, rsp_valid}, 64'd0);
      @(posedge clk); #1;
      chk("rd_lat_rsp", {63'd0, rsp_valid}, 64'd1);
      wait_done();
      chk("rd1_data", 64'(cap_rdata[0]), 64'hF0F0F0F0);
      chk("rd1_last", {63'd0, cap_last[0]}, 64'd1);

      // Burst of three words across a written and an untouched register.
      send(1'b1, 'h008, 32'h15975312, 0);
      wait_done();
      clear_logs();
      send(1'b0, 'h000, 32'h0, 3);
      wait_done();
      chk("burst_count", 64'(cap_rdata.size()), 64'd3);
      chk("burst_d0", 64'(cap_rdata[0]), 64'hF0F0F0F0);
      chk("burst_d1", 64'(cap_rdata[1]), 64'h0);
      chk("burst_d2", 64'(cap_rdata[2]), 64'h15975312);
      chk("burst_lasts", 64'({cap_last[0], cap_last[1], cap_last[2]}), 64'b001);
      chk("burst_a0", 64'(bus_log[0]), 64'h000);
      chk("burst_a1", 64'(bus_log[1]), 64'h004);
      chk("burst_a2", 64'(bus_log[2]), 64'h008);

      // Back-pressure on the first beat of a three-word burst.
      clear_logs();
      rsp_ready = 1'b0;
      send(1'b0, 'h000, 32'h0, 3);
      begin
         logic arrived;
         arrived = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin arrived = 1'b1; break; end
         end
         chk("hold_arrive", {63'd0, arrived}, 64'd1);
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("hold_no_rd_en", {63'd0, rd_en}, 64'd0);
         chk("hold_rdata", 64'(rsp_rdata), 64'hF0F0F0F0);
         chk("hold_last", {63'd0, rsp_last}, 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_done();
      chk("hold_count", 64'(cap_rdata.size()), 64'd3);
      chk("hold_d2", 64'(cap_rdata[2]), 64'h15975312);

      // Rejected commands: misaligned write, read len 0, misaligned read, len 17.
      clear_logs();
      send(1'b1, 'h00F, 32'hDEADBEEF, 0);
      wait_done();
      send(1'b0, 'h000, 32'h0, 0);
      wait_done();
      send(1'b0, 'h002, 32'h0, 2);
      wait_done();
      send(1'b0, 'h000, 32'h0, MAX_BURST + 1);
      wait_done();
      chk("err_count", 64'(cap_rdata.size()), 64'd4);
      chk("err_flags", 64'({cap_err[0], cap_err[1], cap_err[2], cap_err[3]}), 64'hF);
      chk("err_lasts", 64'({cap_last[0], cap_last[1], cap_last[2], cap_last[3]}), 64'hF);
      chk("err_rdata", 64'(cap_rdata[0] | cap_rdata[1] | cap_rdata[2] | cap_rdata[3]), 64'h0);
      chk("err_no_bus", 64'(bus_log.size()), 64'd0);

      // Burst wrapping past the top of the address space.
      send(1'b1, 'h3FC, 32'hA5A5A5A5, 0);
      wait_done();
      clear_logs();
      send(1'b0, 'h3F8, 32'h0, 4);
      wait_done();
      chk("wrap_a0", 64'(bus_log[0]), 64'h3F8);
      chk("wrap_a1", 64'(bus_log[1]), 64'h3FC);
      chk("wrap_a2", 64'(bus_log[2]), 64'h000);
      chk("wrap_a3", 64'(bus_log[3]), 64'h004);
      chk("wrap_d1", 64'(cap_rdata[1]), 64'hA5A5A5A5);
      chk("wrap_d2", 64'(cap_rdata[2]), 64'hF0F0F0F0);
      chk("wrap_last", 64'({cap_last[0], cap_last[1], cap_last[2], cap_last[3]}), 64'b0001);

      // Reset while waiting on read data of a burst.
      send(1'b0, 'h000, 32'h0, 4);
      @(posedge clk); #1;
      rst_n = 1'b0;
      rsp_q.delete(); bus_q.delete();
      for (int i = 0; i < NWORDS; i++) mem_m[i] = '0;
      @(negedge clk);
      check_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_midreset", {63'd0, cmd_ready}, 64'd1);
      clear_logs();
      send(1'b0, 'h000, 32'h0, 1);
      wait_done();
      chk("post_reset_count", 64'(cap_rdata.size()), 64'd1);
      chk("post_reset_data", 64'(cap_rdata[0]), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
